// File: rtl/pdc_pkg.sv
// PDC frame scheduler shared definitions.
// FSM encoding and default timing constants.
package pdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_REQ,
    S_XFER,
    S_GAP
  } state_t;

  localparam int GAP_CYCLES_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 512;

endpackage

// File: rtl/pdc_bank_tracker.sv
// Ping-pong bank occupancy tracker.
// Owns full flags, writer/reader bank pointers and overrun.
import pdc_pkg::*;

module pdc_bank_tracker (
  input  logic       clk,
  input  logic       res_n,
  input  logic       wr_done,
  input  logic       rd_release,
  input  logic       err_clr,
  output logic       wr_bank,
  output logic       wr_ready,
  output logic       rd_bank,
  output logic       rd_full,
  output logic       overrun
);

  logic [1:0] full;
  logic [1:0] full_n;
  logic       wr_ok;

  assign wr_ready = ~full[wr_bank];
  assign rd_full  = full[rd_bank];
  assign wr_ok    = wr_done & wr_ready;

  // Next flags: write sets, read release clears (never the same bank)
  always_comb begin
    full_n = full;
    if (wr_ok)
      full_n[wr_bank] = 1'b1;
    if (rd_release)
      full_n[rd_bank] = 1'b0;
  end

  // Flag, pointer and sticky overrun registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      overrun <= 1'b0;
    end else begin
      full <= full_n;
      if (wr_ok)
        wr_bank <= ~wr_bank;
      if (rd_release)
        rd_bank <= ~rd_bank;
      if (wr_done && !wr_ready)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/pdc_frame_scheduler.sv
// PDC frame scheduler: starts a PDC frame per full bank,
// watches dataReadReq, enforces inter-frame gap and timeout.
import pdc_pkg::*;

module pdc_frame_scheduler #(
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        enable,
  input  logic        wr_done,
  output logic        wr_bank,
  output logic        wr_ready,
  output logic        rd_bank,
  output logic        pdc_on,
  input  logic        pdc_req,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic [15:0] frame_count
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] frame_cnt;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        rd_release;
  logic        frame_inc;
  logic        tmo_evt;
  logic        rd_full;

  pdc_bank_tracker u_bank (
    .clk        (clk),
    .res_n      (res_n),
    .wr_done    (wr_done),
    .rd_release (rd_release),
    .err_clr    (err_clr),
    .wr_bank    (wr_bank),
    .wr_ready   (wr_ready),
    .rd_bank    (rd_bank),
    .rd_full    (rd_full),
    .overrun    (overrun)
  );

  assign busy        = (state != S_IDLE);
  assign frame_count = frame_cnt;

  // Next state and per-state control strobes
  always_comb begin
    state_n    = state;
    pdc_on     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    rd_release = 1'b0;
    frame_inc  = 1'b0;
    tmo_evt    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && rd_full)
          state_n = S_START;
      end
      S_START: begin
        pdc_on  = 1'b1;
        cnt_clr = 1'b1;
        state_n = S_WAIT_REQ;
      end
      S_WAIT_REQ: begin
        if (pdc_req) begin
          state_n = S_XFER;
        end else if (cnt == TMO_LAST) begin
          tmo_evt    = 1'b1;
          rd_release = 1'b1;
          state_n    = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_XFER: begin
        if (!pdc_req) begin
          rd_release = 1'b1;
          frame_inc  = 1'b1;
          cnt_clr    = 1'b1;
          state_n    = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST)
          state_n = S_IDLE;
        else
          cnt_inc = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, shared gap/timeout counter, frame counter, timeout flag
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      frame_cnt   <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (cnt_clr)
        cnt <= 16'd0;
      else if (cnt_inc)
        cnt <= cnt + 16'd1;
      if (frame_inc)
        frame_cnt <= frame_cnt + 16'd1;
      if (tmo_evt)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule
